// File: rtl/pipe_adder_pkg.sv
// Shared defaults for the adder stage and its result buffer.
package pipe_adder_pkg;

    localparam int RES_W     = 32;  // result data width
    localparam int RES_DEPTH = 8;   // result buffer entries (power of two, >= 4)
    localparam int RES_SKID  = 2;   // entries reserved for results in flight when stall rises

    // Occupancy at which the adder must be held off so in-flight results still fit.
    function automatic int stall_level(input int depth, input int skid);
        return depth - skid;
    endfunction

endpackage

// File: rtl/pipe_buf_ptr.sv
// Wrapping read/write pointers, occupancy counter, stall and sticky overflow
// for the result buffer. The memory array itself lives in the parent.
module pipe_buf_ptr
    import pipe_adder_pkg::*;
#(
    parameter int DEPTH = RES_DEPTH,
    parameter int SKID  = RES_SKID
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       flush,
    input  logic                       in_vld,
    input  logic                       out_rdy,
    output logic                       push_o,
    output logic                       pop_o,
    output logic [$clog2(DEPTH)-1:0]   wr_ptr_o,
    output logic [$clog2(DEPTH)-1:0]   rd_ptr_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       stall_o,
    output logic                       overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          stall_q, stall_d;
    logic          ovf_q, ovf_d;
    logic          full;

    assign full = (count_q == CW'(DEPTH));

    // A pop frees the slot in the same edge, so a push while full is allowed
    // whenever the head is leaving. Flush suppresses both.
    assign pop_o  = (count_q != '0) & out_rdy & ~flush;
    assign push_o = in_vld & ~flush & (~full | pop_o);

    // Next-state for pointers, occupancy, stall and overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (in_vld & ~flush & full & ~pop_o);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by natural overflow.
            if (push_o) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_o)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_o, pop_o})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
        stall_d = (count_d >= CW'(stall_level(DEPTH, SKID)));
    end

    // State registers; overflow is sticky until reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            stall_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            stall_q  <= stall_d;
            ovf_q    <= ovf_d;
        end
    end

    assign wr_ptr_o   = wr_ptr_q;
    assign rd_ptr_o   = rd_ptr_q;
    assign count_o    = count_q;
    assign stall_o    = stall_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/pipe_result_buf.sv
// First-word fall-through result buffer between the adder stage and its
// consumer. The adder's result/valid feed in_data/in_vld and stall goes back
// to the adder so results already in flight still land in the skid entries.
module pipe_result_buf
    import pipe_adder_pkg::*;
#(
    parameter int W     = RES_W,
    parameter int DEPTH = RES_DEPTH,
    parameter int SKID  = RES_SKID
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   flush,
    input  logic                   in_vld,
    input  logic [W-1:0]           in_data,
    output logic                   stall,
    output logic                   out_vld,
    output logic [W-1:0]           out_data,
    input  logic                   out_rdy,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    localparam int AW = $clog2(DEPTH);

    logic          push, pop;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [W-1:0]  mem_q [DEPTH];

    pipe_buf_ptr #(
        .DEPTH (DEPTH),
        .SKID  (SKID)
    ) u_ptr (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .in_vld     (in_vld),
        .out_rdy    (out_rdy),
        .push_o     (push),
        .pop_o      (pop),
        .wr_ptr_o   (wr_ptr),
        .rd_ptr_o   (rd_ptr),
        .count_o    (count),
        .stall_o    (stall),
        .overflow_o (overflow)
    );

    // Storage needs no reset: out_data is only meaningful while out_vld is high.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr] <= in_data;
    end

    assign out_vld  = (count != '0);
    assign out_data = mem_q[rd_ptr];

endmodule
